input_conditioner: RTL
======================

# input_conditioner

Conditions the board push-button and two slide switches before they reach the platform's input PIOs (btn, switch, switch2) in the chronometer top level. Each raw input is synchronized and debounced. The button path runs a press/hold state machine that produces single-cycle press, long-press and release pulses. Sticky event flags let software poll for events without missing short pulses.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new level (10 ms at 50 MHz); legal range ≥2.
- LONG_PRESS_CYCLES, 50000000, cycles the debounced button must stay pressed before btn_long fires (1 s); must be greater than DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- btn_raw  in  1  raw key, active-low (0 = pressed), asynchronous to clk.
- sw_raw  in  2  raw slide switches, asynchronous to clk; bit0 drives switch, bit1 drives switch2.
- btn_level  out  1  debounced button, active-high (1 = pressed).
- sw_level  out  2  debounced switch levels.
- btn_press  out  1  one-cycle pulse on an accepted press.
- btn_long  out  1  one-cycle pulse, at most once per press.
- btn_release  out  1  one-cycle pulse on an accepted release.
- sw_change  out  2  per-switch one-cycle pulse on an accepted level change.
- evt  out  3  sticky flags: [0] press, [1] long, [2] any switch change.
- evt_clr  in  3  write-1-to-clear for evt, sampled each cycle.

## Operation
- Synchronizer: 2 flip-flops per input (3 channels). The button is inverted after synchronization.
- Debounce, per channel:
  - Each channel has a counter sized ceil(log2(DEBOUNCE_CYCLES)) bits.
  - If the synced value equals the stable value, the counter is held at 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 and the synced value still differs, the stable value takes the synced value and the counter returns to 0.
  - A glitch shorter than DEBOUNCE_CYCLES restarts the counter and never reaches the output.
- Button FSM states: IDLE, PRESSED, HELD.
  - IDLE→PRESSED on a stable rise; btn_press pulses; the hold counter clears.
  - PRESSED: the hold counter increments each cycle (saturating width ceil(log2(LONG_PRESS_CYCLES))). When it reaches LONG_PRESS_CYCLES-1: →HELD and btn_long pulses.
  - PRESSED or HELD → IDLE on a stable fall; btn_release pulses. A release on the same cycle the hold count completes wins: the state goes to IDLE and btn_long is not emitted.
- sw_change[i] pulses on any accepted change of sw_level[i].
- Sticky flags: each evt bit sets on its source pulse and clears when the matching evt_clr bit is 1. Set and clear on the same cycle leaves the bit at 1 (set wins).

## Timing
- Reset values (applied on the first rising edge with rst=1): all outputs 0; synchronizers, stable values and counters 0; FSM in IDLE.
  - The switch synchronizers reset to 0. A switch that is high at reset is accepted DEBOUNCE_CYCLES+2 edges later with a sw_change pulse.
  - The button stable value resets to released.
- Latency: a clean raw edge before clock edge k appears on btn_level/sw_level at edge k+DEBOUNCE_CYCLES+2. The matching press/release/change pulse is high on that same edge, for exactly one cycle.
- btn_long is high exactly LONG_PRESS_CYCLES cycles after btn_press.
- evt bits rise one cycle after their source pulse. An evt_clr asserted in cycle n clears the bit at edge n+1.
- Reset mid-press: the FSM returns to IDLE and no release pulse is emitted. After rst deasserts, a still-held key produces a fresh btn_press after DEBOUNCE_CYCLES+2 cycles.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20.
1. Reset with btn_raw=1 and sw_raw=00 → all outputs 0. Hold 10 cycles → no pulses.
2. Drive btn_raw to 0 at cycle 0 → btn_level=1 and btn_press=1 at edge 6, both for exactly one cycle of the pulse. Release after 10 cycles → btn_release fires, btn_long never fires.
3. Bounce btn_raw low for 2 cycles, high for 1, repeated 3 times, then hold high → btn_level stays 0, no pulses.
4. Hold the button 30 cycles → btn_long fires once, 20 cycles after btn_press. evt=011. Pulse evt_clr=001 → evt=010.
5. Toggle sw_raw to 10 → sw_change=10 for one cycle and evt[2]=1. Drive evt_clr[2]=1 on the cycle evt[2] would set → evt[2] stays 1.
6. Press the button, assert rst during the HELD state → no btn_release. Deassert rst with the key still held → btn_press fires 6 cycles later.

Source files
------------

// File: rtl/input_conditioner_if.sv
// rtl/input_conditioner_if.sv - raw input / conditioned output bundle for input_conditioner
interface input_conditioner_if;
    logic       btn_raw;
    logic [1:0] sw_raw;
    logic [2:0] evt_clr;
    logic       btn_level;
    logic [1:0] sw_level;
    logic       btn_press;
    logic       btn_long;
    logic       btn_release;
    logic [1:0] sw_change;
    logic [2:0] evt;

    modport slave (
        input  btn_raw, sw_raw, evt_clr,
        output btn_level, sw_level, btn_press, btn_long, btn_release, sw_change, evt
    );

    modport master (
        output btn_raw, sw_raw, evt_clr,
        input  btn_level, sw_level, btn_press, btn_long, btn_release, sw_change, evt
    );
endinterface

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - synchronize/debounce button and switches, press/long/release pulses, sticky events
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int LONG_PRESS_CYCLES = 50000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input_conditioner_if.slave    io
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_PRESS_CYCLES);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

    // Channel 0 is the button, channels 1/2 are the switches.
    logic [2:0]          sync1_q, sync2_q;
    logic [2:0]          synced;
    logic [2:0]          stable_q, stable_d;
    logic [2:0][DW-1:0]  cnt_q, cnt_d;

    state_t              state_q, state_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic                btn_level_q;
    logic                press_q, press_d;
    logic                long_q, long_d;
    logic                release_q, release_d;
    logic [1:0]          sw_level_q;
    logic [1:0]          sw_change_q;
    logic [2:0]          evt_q, evt_d;
    logic                rise, fall;

    // Button flops hold the raw (active-low) level, so they reset to 1: synced "released".
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 3'b001;
            sync2_q <= 3'b001;
        end else begin
            sync1_q <= {io.sw_raw, io.btn_raw};
            sync2_q <= sync1_q;
        end
    end

    assign synced = {sync2_q[2:1], ~sync2_q[0]};

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        for (int i = 0; i < 3; i++) begin
            if (synced[i] != stable_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    stable_d[i] = synced[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign rise = stable_q[0] & ~btn_level_q;
    assign fall = ~stable_q[0] & btn_level_q;

    // A release coinciding with the final hold count takes priority over btn_long.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        press_d   = 1'b0;
        long_d    = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    hold_d  = '0;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = HELD;
                    long_d  = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            HELD: begin
                if (fall) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign evt_d = {|sw_change_q, long_q, press_q} | (evt_q & ~io.evt_clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q    <= '0;
            cnt_q       <= '0;
            state_q     <= IDLE;
            hold_q      <= '0;
            btn_level_q <= 1'b0;
            press_q     <= 1'b0;
            long_q      <= 1'b0;
            release_q   <= 1'b0;
            sw_level_q  <= '0;
            sw_change_q <= '0;
            evt_q       <= '0;
        end else begin
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            btn_level_q <= stable_q[0];
            press_q     <= press_d;
            long_q      <= long_d;
            release_q   <= release_d;
            sw_level_q  <= stable_q[2:1];
            sw_change_q <= stable_q[2:1] ^ sw_level_q;
            evt_q       <= evt_d;
        end
    end

    assign io.btn_level   = btn_level_q;
    assign io.sw_level    = sw_level_q;
    assign io.btn_press   = press_q;
    assign io.btn_long    = long_q;
    assign io.btn_release = release_q;
    assign io.sw_change   = sw_change_q;
    assign io.evt         = evt_q;
endmodule
